// File: rtl/seq_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with pulse, hold and auto-scan modes.
// All outputs come straight from flops; polarity is selected by ACTIVE_LOW.
module seq_decoder #(
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  hold_mode,
  input  logic                  scan_en,
  output logic [(2**SEL_W)-1:0] dout,
  output logic                  valid_out,
  output logic [SEL_W-1:0]      idx_out
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   idx_out_q, idx_out_d;
  logic [OUT_W-1:0]   onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      div_cnt_q <= '0;
      dout_q    <= INACTIVE;
      valid_q   <= 1'b0;
      idx_out_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_cnt_q <= div_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      idx_out_q <= idx_out_d;
    end
  end

  // Priority: !en > scan_en > load; a PULSE state falls back to the IDLE rules.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_cnt_d = div_cnt_q;
    if (!en) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      div_cnt_d = '0;
    end else if (scan_en) begin
      if (state_q != S_SCAN) begin
        state_d   = S_SCAN;
        idx_d     = '0;
        div_cnt_d = '0;
      end else if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        idx_d     = idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else begin
      div_cnt_d = '0;
      case (state_q)
        S_HOLD: begin
          if (load) idx_d = sel;
        end
        S_SCAN: begin
          state_d = S_IDLE;
        end
        default: begin
          if (load) begin
            state_d = hold_mode ? S_HOLD : S_PULSE;
            idx_d   = sel;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are precomputed from the next state so the port flops carry them directly.
  always_comb begin
    valid_d   = (state_d != S_IDLE);
    idx_out_d = valid_d ? idx_d : '0;
    onehot    = '0;
    if (valid_d) onehot[idx_d] = 1'b1;
    dout_d    = onehot ^ INACTIVE;
  end

  assign dout      = dout_q;
  assign valid_out = valid_q;
  assign idx_out   = idx_out_q;

endmodule
